key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 50_000_000, meaning the hold time in clocks for a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter DBL_GAP_CYC, default 12_500_000, meaning the maximum release-to-second-press gap in clocks for a double click (250 ms).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_value_n, input, 3 bits: debounced key levels from the debounce stage; 0 means pressed; bit i is key i+1.
REQ-006 SHALL have port short_pulse, output, 3 bits: one-cycle strobe per key on a short press.
REQ-007 SHALL have port long_pulse, output, 3 bits: one-cycle strobe per key when the long-hold threshold is reached.
REQ-008 SHALL have port dbl_pulse, output, 3 bits: one-cycle strobe per key on a double click.
REQ-009 SHALL have port key_held, output, 3 bits: level per key, high while that key's FSM is in PRESSED, LONG_HELD or SECOND_PRESSED.

Function
REQ-010 SHALL register key_value_n once (key_r) and drive every FSM decision from key_r only.
REQ-011 SHALL run three independent per-key FSMs with states IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED, and a per-key 26-bit counter.
REQ-012 In IDLE, key_r low SHALL go to PRESSED with the counter cleared.
REQ-013 In PRESSED, the counter SHALL increment each cycle; at count LONG_CYC-1 the FSM SHALL pulse long_pulse and go to LONG_HELD.
REQ-014 In PRESSED, key_r high before the threshold SHALL go to WAIT_SECOND with the counter cleared; if release and threshold occur in the same cycle, release wins.
REQ-015 In LONG_HELD, key_r high SHALL go to IDLE with no further pulse.
REQ-016 In WAIT_SECOND, key_r low SHALL go to SECOND_PRESSED; at count DBL_GAP_CYC-1 the FSM SHALL pulse short_pulse and go to IDLE; if both occur in the same cycle, the press wins.
REQ-017 In SECOND_PRESSED, key_r high SHALL pulse dbl_pulse and go to IDLE, regardless of hold length; the counter does not run.
REQ-018 All outputs SHALL be registered; every pulse SHALL be high for exactly one cycle, in the cycle after the FSM transition that generates it.
REQ-019 Per key, at most one of short_pulse, long_pulse or dbl_pulse SHALL be high in any cycle; different keys SHALL be fully independent, including simultaneous presses.
REQ-020 Counters SHALL never wrap: every state that counts exits at its threshold.

Reset
REQ-021 rst_n low SHALL asynchronously set all FSMs to IDLE, counters to 0, key_r to 3'b111, and short_pulse, long_pulse, dbl_pulse and key_held to 0.
REQ-022 Reset asserted mid-press SHALL emit no pulse; after release of reset, a still-pressed key SHALL be treated as a new press (IDLE to PRESSED).

Configuration
REQ-023 With macro KEY_DOUBLE_CLICK_EN defined, the FSM SHALL behave as REQ-011 to REQ-017.
REQ-024 Without KEY_DOUBLE_CLICK_EN: WAIT_SECOND and SECOND_PRESSED are absent; a release in PRESSED SHALL pulse short_pulse and go directly to IDLE; dbl_pulse SHALL be constant 0.

Structure
REQ-025 A shared package key_pkg SHALL hold the FSM state enum, the counter width constant (26), and the key count constant (3).
REQ-026 Per-key logic SHALL live in the sub-module key_event_unit, instantiated three times through a generate loop.

Verification (LONG_CYC=100, DBL_GAP_CYC=20)
REQ-027 Press key1 for 10 cycles then release, macro on: short_pulse[0] pulses exactly once, 20 cycles after release is seen; no other pulse occurs.
REQ-028 Press key2 for 150 cycles: long_pulse[1] pulses once, about 100 cycles after the press; no pulse on release; key_held[1] is high throughout the hold.
REQ-029 Press key3 for 10 cycles, release for 5 cycles, press for 10 cycles, release: dbl_pulse[2] pulses once, at the second release; no short_pulse occurs.
REQ-030 Same stimulus as REQ-027 with the macro off: short_pulse[0] pulses 2 cycles after the input release; dbl_pulse stays at 0 in every scenario.
REQ-031 Assert rst_n low at cycle 50 of a key1 hold: all outputs go to 0 immediately; no long_pulse occurs; after reset release with the key still held, long_pulse[0] fires 100 cycles later.
REQ-032 Press all three keys on the same cycle for 10 cycles: all three short_pulse bits fire on the same cycle.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder.
//   CNT_W    : width of each per-key hold/gap counter
//   NUM_KEYS : number of independent keys
//   key_state_e : per-key FSM state encoding
package key_pkg;

  localparam int unsigned CNT_W    = 26;
  localparam int unsigned NUM_KEYS = 3;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } key_state_e;

endpackage

// File: rtl/key_event_unit.sv
// Per-key press classifier: short press, long press and (optionally) double click.
// Optional feature macro: KEY_DOUBLE_CLICK_EN (adds WAIT_SECOND / SECOND_PRESSED).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   key_r_i    : registered key level, 0 = pressed
//   short_o    : one-cycle strobe on a short press
//   long_o     : one-cycle strobe when the long-hold threshold is reached
//   dbl_o      : one-cycle strobe on a double click (0 when feature disabled)
//   held_o     : high while in PRESSED, LONG_HELD or SECOND_PRESSED
module key_event_unit
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC    = 50_000_000,
  parameter int unsigned DBL_GAP_CYC = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_r_i,
  output logic short_o,
  output logic long_o,
  output logic dbl_o,
  output logic held_o
);

  // Thresholds must be reachable by the counter so it can never wrap.
  if (LONG_CYC < 1 || LONG_CYC > 2**CNT_W) begin : g_bad_long
    $error("LONG_CYC out of counter range");
  end
  if (DBL_GAP_CYC < 1 || DBL_GAP_CYC > 2**CNT_W) begin : g_bad_gap
    $error("DBL_GAP_CYC out of counter range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
`endif

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!key_r_i) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        // Release is tested first so it wins over a coincident threshold.
        if (key_r_i) begin
          cnt_d = '0;
`ifdef KEY_DOUBLE_CLICK_EN
          state_d = ST_WAIT_SECOND;
`else
          state_d = ST_IDLE;
          short_d = 1'b1;
`endif
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (key_r_i) begin
          state_d = ST_IDLE;
        end
      end
`ifdef KEY_DOUBLE_CLICK_EN
      ST_WAIT_SECOND: begin
        // A second press wins over a coincident gap timeout.
        if (!key_r_i) begin
          state_d = ST_SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SECOND_PRESSED: begin
        if (key_r_i) begin
          state_d = ST_IDLE;
          dbl_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) ||
             (state_d == ST_SECOND_PRESSED);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
    end
  end

  assign short_o = short_q;
  assign long_o  = long_q;
  assign dbl_o   = dbl_q;
  assign held_o  = held_q;

endmodule

// File: rtl/key_event_decoder.sv
// Three-key event decoder: registers the debounced key levels once and
// classifies each key independently with a key_event_unit.
// Optional feature macro: KEY_DOUBLE_CLICK_EN (enables double-click detection).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   key_value_n  : debounced key levels, 0 = pressed, bit i = key i+1
//   short_pulse  : per-key short-press strobe
//   long_pulse   : per-key long-press strobe
//   dbl_pulse    : per-key double-click strobe
//   key_held     : per-key held level
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC    = 50_000_000,
  parameter int unsigned DBL_GAP_CYC = 12_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_value_n,
  output logic [NUM_KEYS-1:0] short_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] dbl_pulse,
  output logic [NUM_KEYS-1:0] key_held
);

  logic [NUM_KEYS-1:0] key_r_q;

  // Single input register; all FSM decisions use key_r_q only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r_q <= '1;
    end else begin
      key_r_q <= key_value_n;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_event_unit #(
      .LONG_CYC    (LONG_CYC),
      .DBL_GAP_CYC (DBL_GAP_CYC)
    ) u_unit (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_r_i (key_r_q[i]),
      .short_o (short_pulse[i]),
      .long_o  (long_pulse[i]),
      .dbl_o   (dbl_pulse[i]),
      .held_o  (key_held[i])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder (LONG_CYC=100, DBL_GAP_CYC=20).
// Expected pulse events are queued with their cycle when stimulus is driven
// and matched against the outputs every cycle by a monitor.
module tb_key_event_decoder;

  localparam int unsigned L = 100;
  localparam int unsigned G = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_value_n;
  logic [2:0] short_pulse, long_pulse, dbl_pulse, key_held;

  key_event_decoder #(.LONG_CYC(L), .DBL_GAP_CYC(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_value_n (key_value_n),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .dbl_pulse   (dbl_pulse),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected event: cycle index and {dbl, long, short} vector.
  typedef struct {
    int unsigned at;
    logic [8:0]  vec;
  } exp_t;
  exp_t sb_q[$];

  function automatic void expect_pulse(input int unsigned at, input logic [8:0] vec);
    exp_t e;
    e.at  = at;
    e.vec = vec;
    sb_q.push_back(e);
  endfunction

  logic dbl_seen = 1'b0;

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    logic [8:0] obs;
    forever begin
      @(posedge clk);
      #1;
      obs = {dbl_pulse, long_pulse, short_pulse};
      if (dbl_pulse != 3'b000) dbl_seen = 1'b1;
      while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
        check("missed_event", 32'(obs), 32'(sb_q[0].vec));
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
        check("pulse_event", 32'(obs), 32'(sb_q[0].vec));
        void'(sb_q.pop_front());
      end else if (obs != 9'h000) begin
        check("spurious_pulse", 32'(obs), 32'h0);
      end
    end
  end

  task automatic tick(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  // Cycle of a short pulse for a release driven at cycle m.
  function automatic int unsigned short_at(input int unsigned m);
`ifdef KEY_DOUBLE_CLICK_EN
    return m + 2 + G;
`else
    return m + 2;
`endif
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n, m, r, q;
    rst_n       = 1'b0;
    key_value_n = 3'b111;
    tick(3);
    check("rst_short", 32'(short_pulse), 32'h0);
    check("rst_long",  32'(long_pulse),  32'h0);
    check("rst_dbl",   32'(dbl_pulse),   32'h0);
    check("rst_held",  32'(key_held),    32'h0);
    rst_n = 1'b1;
    tick(5);

    // Key1 short press (10 cycles).
    key_value_n[0] = 1'b0;
    n = cyc;
    tick(5);
    check("k1_held_press", 32'(key_held), 32'h1);
    tick(5);
    key_value_n[0] = 1'b1;
    m = cyc;
    expect_pulse(short_at(m), 9'b000_000_001);
    tick(3);
    check("k1_held_release", 32'(key_held), 32'h0);
    tick(40);

    // Key2 long hold (150 cycles).
    key_value_n[1] = 1'b0;
    n = cyc;
    expect_pulse(n + 2 + L, 9'b000_010_000);
    tick(5);
    check("k2_held_early", 32'(key_held), 32'h2);
    tick(95);
    check("k2_held_mid", 32'(key_held), 32'h2);
    tick(45);
    check("k2_held_late", 32'(key_held), 32'h2);
    tick(5);
    key_value_n[1] = 1'b1;
    tick(3);
    check("k2_held_release", 32'(key_held), 32'h0);
    tick(40);

    // Key3 press 10, gap 5, press 10.
    key_value_n[2] = 1'b0;
    tick(10);
    key_value_n[2] = 1'b1;
    m = cyc;
`ifndef KEY_DOUBLE_CLICK_EN
    expect_pulse(m + 2, 9'b000_000_100);
`endif
    tick(5);
    key_value_n[2] = 1'b0;
    tick(10);
    key_value_n[2] = 1'b1;
    r = cyc;
`ifdef KEY_DOUBLE_CLICK_EN
    expect_pulse(r + 2, 9'b100_000_000);
`else
    expect_pulse(r + 2, 9'b000_000_100);
`endif
    tick(3);
    check("k3_held_release", 32'(key_held), 32'h0);
    tick(40);

    // Reset in the middle of a key1 hold; key stays pressed through reset.
    key_value_n[0] = 1'b0;
    tick(50);
    check("k1_held_before_rst", 32'(key_held), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_held",  32'(key_held),    32'h0);
    check("midrst_short", 32'(short_pulse), 32'h0);
    check("midrst_long",  32'(long_pulse),  32'h0);
    check("midrst_dbl",   32'(dbl_pulse),   32'h0);
    tick(5);
    check("midrst_held_hold", 32'(key_held), 32'h0);
    rst_n = 1'b1;
    q = cyc;
    expect_pulse(q + 2 + L, 9'b000_001_000);
    tick(L + 10);
    check("k1_held_after_rst", 32'(key_held), 32'h1);
    key_value_n[0] = 1'b1;
    tick(3);
    check("k1_held_after_rel", 32'(key_held), 32'h0);
    tick(40);

    // All three keys pressed together for 10 cycles.
    key_value_n = 3'b000;
    tick(5);
    check("all_held", 32'(key_held), 32'h7);
    tick(5);
    key_value_n = 3'b111;
    m = cyc;
    expect_pulse(short_at(m), 9'b000_000_111);
    tick(3);
    check("all_held_release", 32'(key_held), 32'h0);
    tick(40);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
`ifndef KEY_DOUBLE_CLICK_EN
    check("dbl_never", 32'(dbl_seen), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
